// File: rtl/sipo_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sipo_collector: serial-in/parallel-out word assembler with a one-word      |
// | output buffer and sticky overrun. Optional macro: SIPO_PARITY_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sipo_collector #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             in,
   input  logic             clear,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             overrun,
   output logic             parity
);

   localparam int            CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_data;
   logic             r_overrun;
   logic             w_complete;
   logic             w_load;
   logic             w_drop;
   logic [WIDTH-1:0] w_word;

   // clear outranks enable, so a clearing edge can never complete a word
   assign w_complete = enable && !clear && (r_count == c_last);
   assign w_word     = {in, (WIDTH-1)'(r_shift >> 1)};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (enable) begin
         r_shift <= w_word;
         r_count <= w_complete ? '0 : r_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= EMPTY;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_drop = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_complete) begin
               w_load = 1'b1;
               w_next = FULL;
            end
         end
         FULL: begin
            if (w_complete) begin
               // an accept on the same edge frees the slot for the new word
               if (ready) w_load = 1'b1;
               else       w_drop = 1'b1;
            end else if (ready) begin
               w_next = EMPTY;
            end
         end
         default: w_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data    <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load)     r_data    <= w_word;
         if (clear)      r_overrun <= 1'b0;
         else if (w_drop) r_overrun <= 1'b1;
      end
   end

   assign data    = r_data;
   assign valid   = (r_state == FULL);
   assign overrun = r_overrun;

`ifdef SIPO_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      r_parity <= 1'b0;
      else if (w_load) r_parity <= ^w_word;
   end

   assign parity = r_parity;
`else
   assign parity = 1'b0;
`endif

endmodule
`default_nettype wire
